// File: rtl/req_pair_ctrl.sv
// Pairs single-cycle requests from two requesters into one simultaneous req1/req2 pulse.
// Also generates a periodic enable strobe for the downstream counter.
module req_pair_ctrl #(
    parameter int DIV     = 4,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             a_req,
    input  logic             b_req,
    output logic             a_ack,
    output logic             b_ack,
    output logic             enable,
    output logic             req1,
    output logic             req2,
    output logic             timeout,
    output logic [CNT_W-1:0] pair_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {IDLE, HOLD_A, HOLD_B, FIRE} state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               enable_q, enable_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            timeout_q  <= 1'b0;
            pair_cnt_q <= '0;
            div_q      <= '0;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
            pair_cnt_q <= pair_cnt_d;
            div_q      <= div_d;
            enable_q   <= enable_d;
        end
    end

    // FIRE behaves like IDLE for new arrivals so back-to-back requests are not lost.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, FIRE: begin
                wait_d = '0;
                if (a_req && b_req) begin
                    state_d = FIRE;
                end else if (a_req) begin
                    state_d = HOLD_A;
                end else if (b_req) begin
                    state_d = HOLD_B;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD_A: begin
                if (b_req) begin
                    state_d = FIRE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            HOLD_B: begin
                if (a_req) begin
                    state_d = FIRE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        pair_cnt_d = pair_cnt_q;
        if (state_d == FIRE) begin
            pair_cnt_d = pair_cnt_q + 1'b1;
        end
    end

    always_comb begin
        div_d    = '0;
        enable_d = 1'b0;
        if (run) begin
            enable_d = (div_q == DIV_LAST);
            div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    assign req1     = (state_q == FIRE);
    assign req2     = (state_q == FIRE);
    assign a_ack    = (state_q == FIRE);
    assign b_ack    = (state_q == FIRE);
    assign timeout  = timeout_q;
    assign enable   = enable_q;
    assign pair_cnt = pair_cnt_q;

endmodule

// File: doc/req_pair_ctrl.md
Name: req_pair_ctrl

Overview:
Request-pairing and pacing stage directly upstream of the gated event counter. It drives that counter's enable, req1 and req2 inputs. Two independent requesters (A, B) raise single-cycle requests; the block holds the first arrival, waits a bounded time for its partner, then issues req1/req2 together for exactly one cycle and acknowledges both. It also generates a periodic enable strobe from a run level, so the downstream counter advances at a controlled rate.

Parameters:
DIV, 4, enable period in clk cycles (>=1)
TIMEOUT, 8, max cycles a lone request is held before being dropped (>=1)
CNT_W, 8, width of issued-pair counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
run  input  1  level; enables the enable-strobe generator
a_req  input  1  requester A request pulse (sampled every cycle)
b_req  input  1  requester B request pulse
a_ack  output  1  one-cycle ack to A when its request is paired
b_ack  output  1  one-cycle ack to B when its request is paired
enable  output  1  periodic strobe to downstream counter
req1  output  1  paired request, side A, to downstream
req2  output  1  paired request, side B, to downstream
timeout  output  1  one-cycle pulse when a lone request is dropped
pair_cnt  output  CNT_W  number of pairs issued, modulo 2^CNT_W

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all outputs 0; wait and divider counters 0; pair_cnt=0. Reset mid-HOLD/FIRE discards pending requests with no ack or timeout.
- All outputs registered. req1, req2, a_ack, b_ack are decoded from state==FIRE.
- Invariants: req1==req2 every cycle; req1 -> a_ack && b_ack; timeout and req1 never high together.
- FSM states: IDLE, HOLD_A, HOLD_B, FIRE.
- IDLE or FIRE (FIRE always leaves after one cycle):
  - a_req && b_req -> FIRE
  - a_req only -> HOLD_A
  - b_req only -> HOLD_B
  - neither -> IDLE
  - Requests arriving during FIRE are captured this way; they are not lost.
- HOLD_A, with wait_cnt cleared on entry:
  - b_req -> FIRE.
  - Otherwise, if wait_cnt==TIMEOUT-1 -> IDLE with timeout=1 next cycle.
  - Otherwise wait_cnt++.
  - Repeated a_req in HOLD_A is ignored; no double count.
  - b_req on the expiry cycle: FIRE wins, no timeout.
- HOLD_B: symmetric, with the roles of a_req and b_req swapped.
- Latency:
  - Simultaneous requests in cycle n -> req1/req2/acks high in cycle n+1.
  - Partner arriving in cycle m while in HOLD -> FIRE in m+1.
- Lone request timing: request in cycle 0 -> HOLD in cycles 1..TIMEOUT -> cycle TIMEOUT+1 is IDLE with timeout=1.
- pair_cnt increments by 1 on each entry to FIRE; wraps from 2^CNT_W-1 to 0 with no flag.
- Enable generator:
  - div_cnt counts 0..DIV-1 while run=1.
  - enable=1 for the cycle after div_cnt==DIV-1, i.e. one pulse every DIV cycles.
  - run=0: div_cnt cleared and enable=0 from the next cycle.
  - DIV=1: enable is run delayed by one cycle.
  - Enable generator is independent of the pairing FSM.

Test Plan:
- Reset then a_req=b_req=1 in cycle 3 -> cycle 4: req1=req2=a_ack=b_ack=1 for one cycle; pair_cnt=1.
- a_req cycle 0, b_req cycle 5 (TIMEOUT=8) -> cycle 6: req1=req2=1; no timeout; pair_cnt=1.
- a_req cycle 0, no b_req -> cycle 9: timeout=1 for one cycle; no acks; state IDLE; pair_cnt unchanged.
- a_req cycle 0, b_req cycle 8 (expiry cycle) -> cycle 9: req1=req2=1 and timeout=0. Separately, a_req held high during FIRE -> HOLD_A entered the next cycle.
- run=1 from cycle 0 with DIV=4 -> enable high in cycles 4, 8, 12. Drop run in cycle 10 -> no enable from cycle 11. DIV=1 -> enable continuous one cycle after run.
- 256 paired requests with CNT_W=8 -> pair_cnt wraps to 0. Assert rst_n low during HOLD_B -> outputs 0 immediately; no ack after release.
